// File: rtl/playback_rate_gen_if.sv
// Control/data bundle between the playback control FSM, the rate generator,
// and the SRAM address generator / interpolator.
interface playback_rate_gen_if #(
    parameter int RATIO_W = 3
);
    logic [RATIO_W-1:0] ratio_m1;
    logic               isNormalSpeed;
    logic               isSlow;
    logic               interp;
    logic               pause;
    logic               isRecord;
    logic               baseTick;
    logic               sampleTick;
    logic [RATIO_W:0]   sampleStep;
    logic [RATIO_W-1:0] interpPhase;
    logic               interpEn;

    modport master (
        output ratio_m1, isNormalSpeed, isSlow, interp, pause, isRecord,
        input  baseTick, sampleTick, sampleStep, interpPhase, interpEn
    );

    modport slave (
        input  ratio_m1, isNormalSpeed, isSlow, interp, pause, isRecord,
        output baseTick, sampleTick, sampleStep, interpPhase, interpEn
    );
endinterface

// File: rtl/playback_rate_gen.sv
// Playback rate generator: base sample-rate strobe plus per-sample advance
// strobes, address step and slow-mode interpolation phase, all in CLK50.
module playback_rate_gen #(
    parameter int BASE_DIV = 4,
    parameter int RATIO_W  = 3
) (
    input  logic               CLK50,
    input  logic               rst_n,
    playback_rate_gen_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_PAUSE,
        MODE_NORMAL,
        MODE_SLOW,
        MODE_FAST
    } mode_t;

    localparam int               CNT_W    = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BASE_DIV - 1);
    localparam logic [RATIO_W:0] STEP_ONE = {{RATIO_W{1'b0}}, 1'b1};

    logic [CNT_W-1:0]   r_base_cnt;
    logic               r_base_tick;
    logic [RATIO_W-1:0] r_phase;
    logic               r_sample_tick;
    logic [RATIO_W:0]   r_sample_step;
    logic [RATIO_W-1:0] r_ratio_q;
    logic               r_interp_en;

    mode_t              w_mode;
    logic               w_tick_edge;
    logic [CNT_W-1:0]   w_base_cnt;
    logic [RATIO_W-1:0] w_phase;
    logic               w_sample_tick;
    logic [RATIO_W:0]   w_sample_step;
    logic [RATIO_W-1:0] w_ratio_q;
    logic               w_interp_en;

    always_comb begin
        w_mode = MODE_FAST;
        if (bus.pause)
            w_mode = MODE_PAUSE;
        else if (bus.isRecord || bus.isNormalSpeed)
            w_mode = MODE_NORMAL;
        else if (bus.isSlow)
            w_mode = MODE_SLOW;
    end

    // The edge that raises baseTick is also the edge that updates the sample path.
    assign w_tick_edge = (r_base_cnt == CNT_LAST);

    always_comb begin
        w_base_cnt    = w_tick_edge ? '0 : r_base_cnt + CNT_W'(1);
        w_phase       = r_phase;
        w_sample_tick = 1'b0;
        w_sample_step = r_sample_step;
        w_ratio_q     = r_ratio_q;
        w_interp_en   = r_interp_en;

        // Outside SLOW the ratio tracks freely; inside SLOW it only changes at sample boundaries.
        if (w_mode != MODE_SLOW)
            w_ratio_q = bus.ratio_m1;

        if (w_tick_edge) begin
            case (w_mode)
                MODE_PAUSE: begin
                    w_sample_step = STEP_ONE;
                    w_interp_en   = 1'b0;
                end
                MODE_NORMAL: begin
                    w_phase       = '0;
                    w_sample_tick = 1'b1;
                    w_sample_step = STEP_ONE;
                    w_interp_en   = 1'b0;
                end
                MODE_SLOW: begin
                    w_sample_step = STEP_ONE;
                    w_interp_en   = bus.interp;
                    if (r_phase == r_ratio_q) begin
                        w_phase       = '0;
                        w_sample_tick = 1'b1;
                        w_ratio_q     = bus.ratio_m1;
                    end else begin
                        w_phase = r_phase + RATIO_W'(1);
                    end
                end
                default: begin
                    w_phase       = '0;
                    w_sample_tick = 1'b1;
                    w_sample_step = {1'b0, bus.ratio_m1} + STEP_ONE;
                    w_interp_en   = 1'b0;
                end
            endcase
        end

        // Pause/record kill the interpolator right away rather than at the next base tick.
        if (bus.pause || bus.isRecord)
            w_interp_en = 1'b0;
    end

    always_ff @(posedge CLK50 or negedge rst_n) begin
        if (!rst_n) begin
            r_base_cnt    <= '0;
            r_base_tick   <= 1'b0;
            r_phase       <= '0;
            r_sample_tick <= 1'b0;
            r_sample_step <= STEP_ONE;
            r_ratio_q     <= '0;
            r_interp_en   <= 1'b0;
        end else begin
            r_base_cnt    <= w_base_cnt;
            r_base_tick   <= w_tick_edge;
            r_phase       <= w_phase;
            r_sample_tick <= w_sample_tick;
            r_sample_step <= w_sample_step;
            r_ratio_q     <= w_ratio_q;
            r_interp_en   <= w_interp_en;
        end
    end

    assign bus.baseTick    = r_base_tick;
    assign bus.sampleTick  = r_sample_tick;
    assign bus.sampleStep  = r_sample_step;
    assign bus.interpPhase = r_phase;
    assign bus.interpEn    = r_interp_en;
endmodule

// File: tb/tb_playback_rate_gen.sv
// Directed bench for playback_rate_gen with BASE_DIV=4, RATIO_W=3.
module tb_playback_rate_gen;
    logic CLK50;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   n;
    int   sum;

    playback_rate_gen_if #(.RATIO_W(3)) bus ();

    playback_rate_gen #(
        .BASE_DIV (4),
        .RATIO_W  (3)
    ) dut (
        .CLK50 (CLK50),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial CLK50 = 1'b0;
    always #5 CLK50 = ~CLK50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK50);
        @(negedge CLK50);
    endtask

    // Advance to the next baseTick; sampleTick must stay low in between.
    task automatic wait_base(output int cnt);
        cnt = 0;
        do begin
            cycle();
            cnt++;
            if (!bus.baseTick) chk("align", {31'd0, bus.sampleTick}, 0);
        end while (!bus.baseTick && cnt < 16);
        if (!bus.baseTick) chk("base_timeout", {31'd0, bus.baseTick}, 1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.ratio_m1      = 3'd0;
        bus.isNormalSpeed = 1'b1;
        bus.isSlow        = 1'b0;
        bus.interp        = 1'b0;
        bus.pause         = 1'b0;
        bus.isRecord      = 1'b0;

        // 1. reset and base rate
        repeat (3) cycle();
        chk("rst_base",  {31'd0, bus.baseTick},   0);
        chk("rst_stick", {31'd0, bus.sampleTick}, 0);
        chk("rst_step",  {28'd0, bus.sampleStep}, 1);
        chk("rst_phase", {29'd0, bus.interpPhase}, 0);
        chk("rst_en",    {31'd0, bus.interpEn},   0);
        rst_n = 1'b1;
        wait_base(n);
        chk("first_base_n", n, 4);
        chk("norm_stick", {31'd0, bus.sampleTick}, 1);
        chk("norm_step",  {28'd0, bus.sampleStep}, 1);
        wait_base(n);
        chk("base_period", n, 4);
        chk("norm_stick2", {31'd0, bus.sampleTick}, 1);

        // 2. fast mode
        bus.isNormalSpeed = 1'b0;
        bus.ratio_m1      = 3'd2;
        wait_base(n);
        chk("fast_stick", {31'd0, bus.sampleTick}, 1);
        chk("fast_step3", {28'd0, bus.sampleStep}, 3);
        chk("fast_en",    {31'd0, bus.interpEn},   0);
        bus.ratio_m1 = 3'd7;
        wait_base(n);
        chk("fast_step8", {28'd0, bus.sampleStep}, 8);
        bus.ratio_m1 = 3'd3;
        wait_base(n);
        chk("fast_step4", {28'd0, bus.sampleStep}, 4);
        chk("fast_phase", {29'd0, bus.interpPhase}, 0);

        // 3. slow mode, ratio 4
        bus.isSlow = 1'b1;
        bus.interp = 1'b1;
        sum = 0;
        wait_base(n); sum += n;
        chk("slow_ph1",    {29'd0, bus.interpPhase}, 1);
        chk("slow_stick1", {31'd0, bus.sampleTick},  0);
        chk("slow_en",     {31'd0, bus.interpEn},    1);
        chk("slow_step",   {28'd0, bus.sampleStep},  1);
        wait_base(n); sum += n;
        chk("slow_ph2", {29'd0, bus.interpPhase}, 2);
        wait_base(n); sum += n;
        chk("slow_ph3",    {29'd0, bus.interpPhase}, 3);
        chk("slow_stick3", {31'd0, bus.sampleTick},  0);
        wait_base(n); sum += n;
        chk("slow_ph0",    {29'd0, bus.interpPhase}, 0);
        chk("slow_stick0", {31'd0, bus.sampleTick},  1);
        chk("slow_period", sum, 16);
        wait_base(n);
        chk("slow_ph1b", {29'd0, bus.interpPhase}, 1);
        wait_base(n);
        chk("slow_ph2b", {29'd0, bus.interpPhase}, 2);

        // 4. pause at phase 2
        bus.pause = 1'b1;
        cycle();
        chk("pause_en_fast", {31'd0, bus.interpEn}, 0);
        for (int i = 0; i < 5; i++) begin
            wait_base(n);
            chk("pause_n",     n, (i == 0) ? 3 : 4);
            chk("pause_stick", {31'd0, bus.sampleTick},  0);
            chk("pause_phase", {29'd0, bus.interpPhase}, 2);
        end
        bus.pause = 1'b0;
        wait_base(n);
        chk("resume_ph3",   {29'd0, bus.interpPhase}, 3);
        chk("resume_stick", {31'd0, bus.sampleTick},  0);
        chk("resume_en",    {31'd0, bus.interpEn},    1);
        wait_base(n);
        chk("resume_tick",  {31'd0, bus.sampleTick},  1);
        chk("resume_ph0",   {29'd0, bus.interpPhase}, 0);

        // 5. ratio change mid-sample
        wait_base(n);
        chk("rc_ph1", {29'd0, bus.interpPhase}, 1);
        bus.ratio_m1 = 3'd1;
        wait_base(n);
        chk("rc_ph2", {29'd0, bus.interpPhase}, 2);
        wait_base(n);
        chk("rc_ph3",    {29'd0, bus.interpPhase}, 3);
        chk("rc_stick3", {31'd0, bus.sampleTick},  0);
        wait_base(n);
        chk("rc_tick_a", {31'd0, bus.sampleTick},  1);
        chk("rc_ph0a",   {29'd0, bus.interpPhase}, 0);
        wait_base(n);
        chk("rc_ph1b",    {29'd0, bus.interpPhase}, 1);
        chk("rc_stick1b", {31'd0, bus.sampleTick},  0);
        wait_base(n);
        chk("rc_tick_b", {31'd0, bus.sampleTick},  1);
        chk("rc_ph0b",   {29'd0, bus.interpPhase}, 0);

        // 6. record mid-slow at phase 2 (ratio back to 4 after next boundary)
        bus.ratio_m1 = 3'd3;
        wait_base(n);
        chk("rec_ph1", {29'd0, bus.interpPhase}, 1);
        wait_base(n);
        chk("rec_tick_pre", {31'd0, bus.sampleTick}, 1);
        wait_base(n);
        wait_base(n);
        chk("rec_ph2", {29'd0, bus.interpPhase}, 2);
        chk("rec_en1", {31'd0, bus.interpEn},    1);
        bus.isRecord = 1'b1;
        cycle();
        chk("rec_en_fast", {31'd0, bus.interpEn}, 0);
        wait_base(n);
        chk("rec_stick", {31'd0, bus.sampleTick},  1);
        chk("rec_step",  {28'd0, bus.sampleStep},  1);
        chk("rec_phase", {29'd0, bus.interpPhase}, 0);

        // 7. reset mid-operation, then SLOW with ratio_m1=0
        bus.isRecord = 1'b0;
        bus.ratio_m1 = 3'd7;
        bus.isSlow   = 1'b0;
        wait_base(n);
        chk("pre_rst_step", {28'd0, bus.sampleStep}, 8);
        cycle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_step",  {28'd0, bus.sampleStep}, 1);
        chk("mid_rst_stick", {31'd0, bus.sampleTick}, 0);
        @(negedge CLK50);
        bus.isSlow   = 1'b1;
        bus.ratio_m1 = 3'd0;
        bus.interp   = 1'b1;
        rst_n = 1'b1;
        wait_base(n);
        chk("r0_first_n", n, 4);
        chk("r0_stick",   {31'd0, bus.sampleTick},  1);
        chk("r0_phase",   {29'd0, bus.interpPhase}, 0);
        wait_base(n);
        chk("r0_stick2",  {31'd0, bus.sampleTick},  1);
        chk("r0_phase2",  {29'd0, bus.interpPhase}, 0);
        chk("r0_en",      {31'd0, bus.interpEn},    1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/playback_rate_gen.md
Name: playback_rate_gen

Overview:
- Parametrised successor to the audio-board playback clock divider. It runs in the single CLK50 domain and generates no derived clocks.
- Produces a base sample-rate strobe plus per-sample advance strobes for record, normal, fast (N×) and slow (1/N) playback.
- Supplies a step size for the sample address counter and an interpolation phase for the slow-mode linear interpolator.
- Sits between the control FSM (mode and ratio inputs) and the SRAM address generator / interpolator.

Parameters:
BASE_DIV, 4, CLK50 cycles per base tick (≥2)
RATIO_W, 3, width of ratio_m1; speed ratio = ratio_m1+1, range 1..2^RATIO_W

Ports:
CLK50  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
ratio_m1  input  RATIO_W  speed ratio minus 1
isNormalSpeed  input  1  1 = 1× playback
isSlow  input  1  1 = slow mode, 0 = fast mode (ignored when isNormalSpeed=1)
interp  input  1  enable interpolation in slow mode
pause  input  1  freeze sample advance
isRecord  input  1  record mode; forces 1× behaviour
baseTick  output  1  1-cycle strobe every BASE_DIV clocks
sampleTick  output  1  1-cycle strobe: advance sample address
sampleStep  output  RATIO_W+1  address increment; valid when sampleTick=1
interpPhase  output  RATIO_W  position inside current slow sample, 0..ratio_q
interpEn  output  1  interpolator enable

Behaviour:
- Reset (async, rst_n=0): all internal counters = 0, ratio_q = 0; all outputs = 0, except sampleStep = 1.
- Base counter:
  - Counts 0..BASE_DIV-1 and wraps.
  - baseTick is registered and equals 1 in the cycle after the counter reaches BASE_DIV-1.
  - First baseTick is on the BASE_DIV-th rising edge after reset release, then every BASE_DIV cycles.
  - baseTick is unaffected by every mode input, including pause.
- Mode decode, sampled on the clock edge that produces baseTick, priority high to low:
  - PAUSE: pause=1
  - NORMAL: isRecord=1 or isNormalSpeed=1
  - SLOW: isSlow=1
  - FAST: otherwise
- ratio_q:
  - Registered copy of ratio_m1.
  - Loaded only on edges where sampleTick is produced, or when mode ≠ SLOW.
  - A ratio change mid-sample in SLOW takes effect after the current sample completes.
- Slow phase counter (phase, RATIO_W bits), updated only on base-tick edges:
  - SLOW: if phase == ratio_q, then phase ← 0 and sampleTick ← 1; else phase ← phase+1 and sampleTick ← 0.
  - PAUSE: phase held, sampleTick ← 0.
  - NORMAL or FAST: phase ← 0, sampleTick ← 1.
- Slow-mode sampleTick cadence:
  - Once every ratio_q+1 base ticks.
  - The first sampleTick after entering SLOW occurs on the base tick where phase == ratio_q, with phase counted from 0.
- sampleStep:
  - Registered and updated together with sampleTick.
  - ratio_q+1 in FAST; uses the newly loaded ratio_m1 value, i.e. ratio_m1+1, zero-extended.
  - 1 in all other modes.
  - Held between ticks.
- interpPhase = phase register. Holds its value when paused.
- interpEn:
  - Registered; = interp & (mode == SLOW), evaluated on base-tick edges.
  - Forced to 0 immediately in the cycle after pause or isRecord rises; this path does not wait for a base tick.
- Strobe alignment: sampleTick and baseTick assert in the same cycle, and sampleTick is never 1 when baseTick is 0.
- Boundaries:
  - ratio_m1 = 0 in SLOW: sampleTick on every base tick, interpPhase stays 0.
  - ratio_m1 = max in FAST: step = 2^RATIO_W, no overflow thanks to the RATIO_W+1 width.
  - Leaving PAUSE: counting resumes from the held phase.
  - SLOW→FAST/NORMAL mid-sample: the partial sample is dropped; tick issued at the next base tick.
- Reset mid-operation: outputs cleared in the same cycle; no strobe is emitted on the release edge.

Test Plan:
1. Reset and base rate (BASE_DIV=4, RATIO_W=3): hold rst_n=0 for 3 cycles, then release with normal mode → all outputs 0 during reset; baseTick=sampleTick=1 on cycles 4, 8, 12…; sampleStep=1.
2. FAST, ratio_m1=2 → sampleTick on every baseTick, sampleStep=3. Then set ratio_m1=7 → next tick sampleStep=8.
3. SLOW, ratio_m1=3, interp=1 → sampleTick every 16 clocks; interpPhase sequence 0,1,2,3,0 on successive baseTicks; interpEn=1; sampleStep=1.
4. PAUSE at interpPhase=2 for 5 baseTicks → no sampleTick; interpPhase held at 2; interpEn=0 one cycle after pause rises; baseTick continues. On release → next phase 3, then sampleTick.
5. SLOW ratio_m1=3 at phase 1, change ratio_m1 to 1 → phases 2, 3 then sampleTick, then period of 2 base ticks (phases 0, 1).
6. isRecord asserted mid-SLOW at phase 2 → next baseTick gives sampleTick=1, sampleStep=1, interpPhase=0; interpEn=0 one cycle after isRecord rises.
